// File: rtl/vga_frame_animator.sv
// rtl/vga_frame_animator.sv - per-frame bouncing sprite centre and animation phase counter
module vga_frame_animator #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int RADIUS   = 64,
    parameter int INIT_X   = 320,
    parameter int INIT_Y   = 240
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       vsync,
    input  logic [1:0] speed,
    input  logic       pause,
    input  logic       reverse,
    input  logic       step_req,
    output logic       frame_tick,
    output logic [9:0] counter,
    output logic [9:0] center_x,
    output logic [9:0] center_y,
    output logic       dir_x,
    output logic       dir_y,
    output logic       busy
);

    localparam logic [11:0] X_MIN_W = 12'(RADIUS);
    localparam logic [11:0] X_MAX_W = 12'(H_ACTIVE - 1 - RADIUS);
    localparam logic [11:0] Y_MIN_W = 12'(RADIUS);
    localparam logic [11:0] Y_MAX_W = 12'(V_ACTIVE - 1 - RADIUS);
    localparam logic [9:0]  X_MIN_N = 10'(RADIUS);
    localparam logic [9:0]  X_MAX_N = 10'(H_ACTIVE - 1 - RADIUS);
    localparam logic [9:0]  Y_MIN_N = 10'(RADIUS);
    localparam logic [9:0]  Y_MAX_N = 10'(V_ACTIVE - 1 - RADIUS);

    typedef enum logic [1:0] {S_WAIT, S_CALC_X, S_CALC_Y, S_COMMIT} state_t;
    state_t state, state_nxt;

    logic       vsync_q, step_q, armed, step_edge;
    logic [3:0] step_lat, step_y;
    logic       rev_lat, start;
    logic [9:0] nx, ny, bx, by;
    logic       ndx, ndy, bdx, bdy;

    // armed holds off edge detection for the first cycle after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q    <= 1'b1;
            step_q     <= 1'b0;
            armed      <= 1'b0;
            frame_tick <= 1'b0;
            step_edge  <= 1'b0;
        end else begin
            vsync_q    <= vsync;
            step_q     <= step_req;
            armed      <= 1'b1;
            frame_tick <= armed & vsync_q & ~vsync;
            step_edge  <= armed & ~step_q & step_req;
        end
    end

    assign start = (state == S_WAIT) && (pause ? step_edge : frame_tick);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_WAIT;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_WAIT:   if (start) state_nxt = S_CALC_X;
            S_CALC_X: state_nxt = S_CALC_Y;
            S_CALC_Y: state_nxt = S_COMMIT;
            default:  state_nxt = S_WAIT;
        endcase
    end

    always_comb begin
        busy = (state != S_WAIT);
    end

    assign step_y = (step_lat[3:1] == 3'd0) ? 4'd1 : {1'b0, step_lat[3:1]};

    // limit compares are done at 12 bits so x+S and MIN+S never wrap
    always_comb begin
        bx  = center_x;
        bdx = dir_x;
        if (dir_x) begin
            if ({2'b00, center_x} + {8'd0, step_lat} >= X_MAX_W) begin
                bx  = X_MAX_N;
                bdx = 1'b0;
            end else begin
                bx = center_x + {6'd0, step_lat};
            end
        end else begin
            if ({2'b00, center_x} <= X_MIN_W + {8'd0, step_lat}) begin
                bx  = X_MIN_N;
                bdx = 1'b1;
            end else begin
                bx = center_x - {6'd0, step_lat};
            end
        end
    end

    always_comb begin
        by  = center_y;
        bdy = dir_y;
        if (dir_y) begin
            if ({2'b00, center_y} + {8'd0, step_y} >= Y_MAX_W) begin
                by  = Y_MAX_N;
                bdy = 1'b0;
            end else begin
                by = center_y + {6'd0, step_y};
            end
        end else begin
            if ({2'b00, center_y} <= Y_MIN_W + {8'd0, step_y}) begin
                by  = Y_MIN_N;
                bdy = 1'b1;
            end else begin
                by = center_y - {6'd0, step_y};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_lat <= 4'd1;
            rev_lat  <= 1'b0;
            nx       <= 10'(INIT_X);
            ny       <= 10'(INIT_Y);
            ndx      <= 1'b1;
            ndy      <= 1'b1;
            counter  <= 10'd0;
            center_x <= 10'(INIT_X);
            center_y <= 10'(INIT_Y);
            dir_x    <= 1'b1;
            dir_y    <= 1'b1;
        end else begin
            if (start) begin
                step_lat <= 4'd1 << speed;
                rev_lat  <= reverse;
            end
            if (state == S_CALC_X) begin
                nx  <= bx;
                ndx <= bdx;
            end
            if (state == S_CALC_Y) begin
                ny  <= by;
                ndy <= bdy;
            end
            if (state == S_COMMIT) begin
                counter  <= rev_lat ? counter - {6'd0, step_lat} : counter + {6'd0, step_lat};
                center_x <= nx;
                center_y <= ny;
                dir_x    <= ndx;
                dir_y    <= ndy;
            end
        end
    end

endmodule

// File: tb/tb_vga_frame_animator.sv
// tb/tb_vga_frame_animator.sv - directed bench with a cycle-level reference model of the animator
module tb_vga_frame_animator;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       vsync = 1'b1;
    logic [1:0] speed = 2'd0;
    logic       pause = 1'b0;
    logic       reverse = 1'b0;
    logic       step_req = 1'b0;
    logic       frame_tick, dir_x, dir_y, busy;
    logic [9:0] counter, center_x, center_y;

    int errors = 0;
    int checks = 0;
    int ft_count = 0;
    int busy_cycles = 0;

    // reference model state
    int m_x, m_y, m_cnt, m_s, m_left;
    bit m_dx, m_dy, m_rev, m_ft, m_se, m_vs, m_sr, m_armed, m_start;

    vga_frame_animator dut (
        .clk(clk), .rst_n(rst_n), .vsync(vsync), .speed(speed), .pause(pause),
        .reverse(reverse), .step_req(step_req), .frame_tick(frame_tick),
        .counter(counter), .center_x(center_x), .center_y(center_y),
        .dir_x(dir_x), .dir_y(dir_y), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void bounce(input int p, input bit d, input int s, input int lo,
                                   input int hi, output int np, output bit nd);
        nd = d;
        if (d) begin
            if (p + s >= hi) begin np = hi; nd = 1'b0; end
            else np = p + s;
        end else begin
            if (p <= lo + s) begin np = lo; nd = 1'b1; end
            else np = p - s;
        end
    endfunction

    // the outcome of an update is fixed at its start and appears three edges later
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_x = 320; m_y = 240; m_cnt = 0; m_dx = 1; m_dy = 1;
            m_left = 0; m_s = 1; m_rev = 0;
            m_ft = 0; m_se = 0; m_vs = 1; m_sr = 0; m_armed = 0;
        end else begin
            m_start = (m_left == 0) && (pause ? m_se : m_ft);
            if (m_left > 0) begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_cnt = m_rev ? (m_cnt + 1024 - m_s) % 1024 : (m_cnt + m_s) % 1024;
                    bounce(m_x, m_dx, m_s, 64, 575, m_x, m_dx);
                    bounce(m_y, m_dy, (m_s / 2 > 1) ? m_s / 2 : 1, 64, 415, m_y, m_dy);
                end
            end else if (m_start) begin
                m_s = 1 << speed;
                m_rev = reverse;
                m_left = 3;
            end
            m_ft = m_armed && m_vs && !vsync;
            m_se = m_armed && !m_sr && step_req;
            m_vs = vsync;
            m_sr = step_req;
            m_armed = 1;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("frame_tick", int'(frame_tick), int'(m_ft));
            check("busy", int'(busy), int'(m_left != 0));
            check("counter", int'(counter), m_cnt);
            check("center_x", int'(center_x), m_x);
            check("center_y", int'(center_y), m_y);
            check("dir_x", int'(dir_x), int'(m_dx));
            check("dir_y", int'(dir_y), int'(m_dy));
            check("x_range", int'(center_x >= 64 && center_x <= 575), 1);
            check("y_range", int'(center_y >= 64 && center_y <= 415), 1);
            if (frame_tick) ft_count++;
            if (busy) busy_cycles++;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; vsync = 1'b1; step_req = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        ft_count = 0;
        busy_cycles = 0;
    endtask

    task automatic frame();
        @(negedge clk);
        vsync = 1'b0;
        repeat (2) @(negedge clk);
        vsync = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic step_pulse();
        @(negedge clk);
        step_req = 1'b1;
        @(negedge clk);
        step_req = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic check_pos(input string tag, input int cnt, input int x, input int y);
        check({tag, "_counter"}, int'(counter), cnt);
        check({tag, "_cx"}, int'(center_x), x);
        check({tag, "_cy"}, int'(center_y), y);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_tick", int'(frame_tick), 0);
        check_pos("rst", 0, 320, 240);
        check("rst_dirs", int'({dir_x, dir_y}), 3);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // three frames at speed 0
        repeat (3) frame();
        check("three_ticks", ft_count, 3);
        check_pos("three", 3, 323, 243);
        // step edge without pause is ignored
        step_pulse();
        check_pos("step_nopause", 3, 323, 243);

        // right-edge bounce at speed 3
        do_reset();
        speed = 2'd3;
        repeat (31) frame();
        check_pos("pre_bounce", 248, 568, 364);
        check("pre_bounce_dx", int'(dir_x), 1);
        frame();
        check("bounce_cx", int'(center_x), 575);
        check("bounce_dx", int'(dir_x), 0);
        frame();
        check("after_bounce_cx", int'(center_x), 567);

        // reverse counting wraps below zero
        do_reset();
        speed = 2'd1; reverse = 1'b1;
        frame();
        check_pos("reverse", 1022, 322, 241);
        reverse = 1'b0; speed = 2'd0;

        // pause holds everything until a step request
        do_reset();
        pause = 1'b1;
        repeat (2) frame();
        check("pause_ticks", ft_count, 2);
        check_pos("paused", 0, 320, 240);
        busy_cycles = 0;
        step_pulse();
        check("step_busy_cycles", busy_cycles, 3);
        check_pos("stepped", 1, 321, 241);
        pause = 1'b0;

        // asynchronous reset during CALC_Y, vsync held low through release
        do_reset();
        frame();
        @(negedge clk);
        vsync = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_reset_busy", int'(busy), 1);
        #1 rst_n = 1'b0;
        #1;
        check("async_busy", int'(busy), 0);
        check_pos("async", 0, 320, 240);
        @(negedge clk);
        @(negedge clk);
        ft_count = 0;
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("no_tick_after_release", ft_count, 0);
        check_pos("post_release", 0, 320, 240);
        vsync = 1'b1;

        // speed change right after frame_tick waits for the next update
        do_reset();
        speed = 2'd0;
        @(negedge clk);
        vsync = 1'b0;
        @(negedge clk);
        check("tick_seen", int'(frame_tick), 1);
        @(negedge clk);
        speed = 2'd3;
        vsync = 1'b1;
        repeat (8) @(negedge clk);
        check_pos("late_speed", 1, 321, 241);
        frame();
        check_pos("new_speed", 9, 329, 245);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
